// File: rtl/control_unit.sv
// Instruction sequencer for the base processor: captures an instruction in T0 and
// steps T1..T3 while decoding register enables and bus-driver selects from state and ir.
//
// state | meaning
// T0    | idle / fetch: all outputs 0, capture din into ir when run=1
// T1    | mv/mvi/illegal complete here; add/sub load A from Rx
// T2    | add/sub: G <= A +/- Ry
// T3    | add/sub: Rx <= G, instruction done
module control_unit #(
  parameter int NUM_REGS = 8,
  parameter int IR_WIDTH = 9
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                run,
  input  logic [IR_WIDTH-1:0] din,
  output logic [IR_WIDTH-1:0] ir,
  output logic [NUM_REGS-1:0] rin,
  output logic [NUM_REGS-1:0] rout,
  output logic                gout,
  output logic                dinout,
  output logic                ain,
  output logic                gin,
  output logic                addsub,
  output logic                done
);

  typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  state_t state, state_nxt;

  logic [2:0]          opcode;
  logic [2:0]          rx;
  logic [2:0]          ry;
  logic [NUM_REGS-1:0] x_sel;
  logic [NUM_REGS-1:0] y_sel;

  assign opcode = ir[8:6];
  assign rx     = ir[5:3];
  assign ry     = ir[2:0];
  assign x_sel  = {{(NUM_REGS-1){1'b0}}, 1'b1} << rx;
  assign y_sel  = {{(NUM_REGS-1){1'b0}}, 1'b1} << ry;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= T0;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (state == T0 && run) begin
        ir <= din;
      end
    end
  end

  // Outputs depend only on state and ir, so an async reset to T0 clears them at once.
  always_comb begin
    state_nxt = state;
    rin       = '0;
    rout      = '0;
    gout      = 1'b0;
    dinout    = 1'b0;
    ain       = 1'b0;
    gin       = 1'b0;
    addsub    = 1'b0;
    done      = 1'b0;
    case (state)
      T0: begin
        if (run) begin
          state_nxt = T1;
        end
      end
      T1: begin
        case (opcode)
          OP_MV: begin
            rout      = y_sel;
            rin       = x_sel;
            done      = 1'b1;
            state_nxt = T0;
          end
          OP_MVI: begin
            dinout    = 1'b1;
            rin       = x_sel;
            done      = 1'b1;
            state_nxt = T0;
          end
          OP_ADD, OP_SUB: begin
            rout      = x_sel;
            ain       = 1'b1;
            state_nxt = T2;
          end
          default: begin
            done      = 1'b1;
            state_nxt = T0;
          end
        endcase
      end
      T2: begin
        rout      = y_sel;
        gin       = 1'b1;
        addsub    = (opcode == OP_SUB);
        state_nxt = T3;
      end
      T3: begin
        gout      = 1'b1;
        rin       = x_sel;
        done      = 1'b1;
        state_nxt = T0;
      end
      default: begin
        state_nxt = T0;
      end
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed scenarios plus random run/din traffic
// compared against a micro-op queue model of the instruction set.
module tb_control_unit;

  logic       clock = 1'b0;
  logic       reset;
  logic       run;
  logic [8:0] din;
  logic [8:0] ir;
  logic [7:0] rin;
  logic [7:0] rout;
  logic       gout, dinout, ain, gin, addsub, done;

  int total = 0;
  int bad   = 0;

  // {rin, rout, gout, dinout, ain, gin, addsub, done}
  typedef logic [21:0] uop_t;
  uop_t       q[$];
  logic [8:0] m_ir;

  control_unit #(.NUM_REGS(8), .IR_WIDTH(9)) dut (
    .clock(clock), .reset(reset), .run(run), .din(din), .ir(ir),
    .rin(rin), .rout(rout), .gout(gout), .dinout(dinout), .ain(ain),
    .gin(gin), .addsub(addsub), .done(done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic uop_t mk(input logic [7:0] rin_v, input logic [7:0] rout_v,
                              input logic g, input logic di, input logic a,
                              input logic gi, input logic as_v, input logic d);
    return {rin_v, rout_v, g, di, a, gi, as_v, d};
  endfunction

  // Each instruction expands into the list of cycle outputs it produces after T0.
  function automatic void load(input logic [8:0] instr);
    logic [7:0] bx;
    logic [7:0] by;
    bx = 8'd1 << instr[5:3];
    by = 8'd1 << instr[2:0];
    case (instr[8:6])
      3'd0: q.push_back(mk(bx, by, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
      3'd1: q.push_back(mk(bx, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
      3'd2, 3'd3: begin
        q.push_back(mk(8'h00, bx, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        q.push_back(mk(8'h00, by, 1'b0, 1'b0, 1'b0, 1'b1, instr[6], 1'b0));
        q.push_back(mk(bx, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
      end
      default: q.push_back(mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    endcase
  endfunction

  function automatic logic [31:0] outs();
    return {10'b0, rin, rout, gout, dinout, ain, gin, addsub, done};
  endfunction

  // Called at posedge+1: drive inputs, check this cycle, advance model on the edge.
  task automatic cycle(input logic r, input logic [8:0] d, input string tag);
    uop_t e;
    run = r;
    din = d;
    e = (q.size() == 0) ? 22'b0 : q[0];
    check({tag, ":outs"}, outs(), {10'b0, e});
    check({tag, ":ir"}, {23'b0, ir}, {23'b0, m_ir});
    check({tag, ":busdrv"}, {31'b0, ($countones({rout, gout, dinout}) <= 1)}, 32'd1);
    check({tag, ":rin1h"}, {31'b0, ($countones(rin) <= 1)}, 32'd1);
    @(posedge clock);
    if (q.size() == 0) begin
      if (r) begin
        m_ir = d;
        load(d);
      end
    end else begin
      void'(q.pop_front());
    end
    #1;
  endtask

  initial begin
    reset = 1'b1;
    run   = 1'b0;
    din   = 9'h000;
    m_ir  = 9'h000;
    @(posedge clock);
    #1;
    check("rst_outs", outs(), 32'h0);
    check("rst_ir", {23'b0, ir}, 32'h0);
    reset = 1'b0;

    // mvi R0, #5
    cycle(1'b1, 9'b001_000_000, "mvi_t0");
    check("mvi_t1", {dinout, done, rin, ir}, {1'b1, 1'b1, 8'h01, 9'h040});
    cycle(1'b0, 9'h005, "mvi_t1");
    cycle(1'b0, 9'h000, "mvi_back");

    // mv R1, R0
    cycle(1'b1, 9'b000_001_000, "mv_t0");
    check("mv_t1", outs(), {10'b0, 8'h02, 8'h01, 6'b000001});
    cycle(1'b0, 9'h000, "mv_t1");

    // add R0, R1
    cycle(1'b1, 9'b010_000_001, "add_t0");
    cycle(1'b0, 9'h000, "add_t1");
    check("add_t2", {rout, gin, addsub}, {8'h02, 1'b1, 1'b0});
    cycle(1'b0, 9'h000, "add_t2");
    check("add_t3", {gout, rin, done}, {1'b1, 8'h01, 1'b1});
    cycle(1'b0, 9'h000, "add_t3");

    // sub R7, R3 with run held high; run must be ignored until the next T0
    cycle(1'b1, 9'b011_111_011, "sub_t0");
    cycle(1'b1, 9'h1ff, "sub_t1");
    check("sub_t2", {23'b0, addsub}, 32'd1);
    cycle(1'b1, 9'h1ff, "sub_t2");
    check("sub_t3", {24'b0, rin}, 32'h80);
    cycle(1'b1, 9'h1ff, "sub_t3");
    cycle(1'b1, 9'b000_010_100, "sub_next_t0");
    check("sub_next_ir", {23'b0, ir}, {23'b0, 9'b000_010_100});
    cycle(1'b0, 9'h000, "sub_next_t1");

    // async reset during T2 of add
    cycle(1'b1, 9'b010_000_001, "arst_t0");
    cycle(1'b0, 9'h000, "arst_t1");
    #2;
    reset = 1'b1;
    #1;
    check("arst_outs", outs(), 32'h0);
    check("arst_ir", {23'b0, ir}, 32'h0);
    q.delete();
    m_ir = 9'h000;
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    cycle(1'b0, 9'h000, "arst_idle");
    cycle(1'b1, 9'b000_011_011, "mv33_t0");
    check("mv33_t1", {rout, rin}, {8'h08, 8'h08});
    cycle(1'b0, 9'h000, "mv33_t1");

    // illegal opcode
    cycle(1'b1, 9'b100_010_001, "ill_t0");
    check("ill_t1", outs(), 32'h1);
    cycle(1'b0, 9'h000, "ill_t1");
    cycle(1'b0, 9'h000, "ill_back");

    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 3) != 0), 9'($urandom_range(0, 511)), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
